div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Execute-stage initiator for the iterative divider: accepts RV32M divide/remainder instructions and drives the divider's start/operand interface.
- Stalls the pipeline while the divide runs.
- Writes the result back to the register file when the divider completes.
- Handles flushes (jump/interrupt) and a watchdog so a lost completion can never deadlock the core.

Parameters:
- WATCHDOG, 40, max cycles from issue to div_ready_i before abort (divider nominal latency is ~34 cycles).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- inst_div_i  in  1  EX holds a valid DIV/DIVU/REM/REMU instruction this cycle
- op_i  in  3  funct3 (100 div, 101 divu, 110 rem, 111 remu)
- rs1_data_i  in  32  dividend
- rs2_data_i  in  32  divisor
- rd_i  in  5  destination register
- flush_i  in  1  pipeline flush (jump/interrupt)
- hold_o  out  1  stall request to pipeline control
- div_start_o  out  1  start to divider
- div_dividend_o  out  32  latched dividend
- div_divisor_o  out  32  latched divisor
- div_op_o  out  3  latched funct3
- div_reg_waddr_o  out  5  latched rd tag
- div_result_i  in  32  divider result
- div_ready_i  in  1  divider one-cycle completion pulse
- div_busy_i  in  1  divider busy
- div_reg_waddr_i  in  5  tag returned with result
- reg_we_o  out  1  register-file write enable pulse
- reg_waddr_o  out  5  write address
- reg_wdata_o  out  32  write data
- timeout_o  out  1  sticky watchdog error flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; operand/tag/watchdog registers 0; timeout_o cleared only by reset.
- Divider contract:
  - The divider latches operands on the first rising edge with start_i=1 while not busy.
  - Once started, it runs to completion regardless of start_i.
  - It pulses ready_o for exactly one cycle with result and tag.
  - It requires start_i=0 for at least one cycle before the next operation.
- States: IDLE, WAIT, DRAIN, GAP.
- IDLE:
  - On inst_div_i=1 and flush_i=0 and div_busy_i=0: latch rs1/rs2/op/rd, set div_start_o=1, clear watchdog counter, go to WAIT.
  - hold_o is combinationally 1 in this issue cycle.
  - If div_busy_i=1: no issue; hold_o=1 while inst_div_i=1.
- WAIT:
  - div_start_o=1, hold_o=1, watchdog counter increments every cycle.
  - On div_ready_i: next cycle reg_we_o=1, reg_waddr_o=div_reg_waddr_i, reg_wdata_o=div_result_i for exactly one cycle.
  - reg_we_o is suppressed if rd=0 or div_reg_waddr_i differs from the latched tag; a tag mismatch also sets timeout_o.
  - div_start_o cleared on the same edge; go to GAP. hold_o is high in the div_ready_i cycle and low from the next cycle.
  - flush_i=1 (without ready in the same cycle): div_start_o cleared, hold_o=0 from next cycle, go to DRAIN.
  - ready and flush in the same cycle: the result is discarded (no reg_we_o); go to GAP.
  - Watchdog counter reaching WATCHDOG: set timeout_o, clear start, go to DRAIN.
- DRAIN:
  - hold_o = inst_div_i (no new issue until drained); no writeback.
  - On div_ready_i, or div_busy_i=0 with no ready, go to GAP.
- GAP:
  - Exactly one cycle with div_start_o=0 and hold_o = inst_div_i, then IDLE.
  - Back-to-back divides therefore issue at most every N+2 cycles.
- div_dividend_o, div_divisor_o, div_op_o, div_reg_waddr_o hold their latched values until the next issue.
- Writeback data is passed through unmodified; divide-by-zero and overflow semantics belong to the divider.
- Reset mid-operation returns to IDLE immediately, with outputs zeroed, on rst falling.

Test Plan:
- DIVU 14/2, rd=1, divider returns 7 with tag 1 -> div_start_o high from issue through the ready cycle; hold_o high issue..ready; one-cycle reg_we_o with waddr=1, wdata=7; start low in GAP.
- REM -7/2 (0xFFFFFFF9, 2), rd=5, result 0xFFFFFFFF -> single writeback waddr=5, wdata=0xFFFFFFFF; latched op=110 on div_op_o.
- DIV with rd=0, result 3 -> reg_we_o never asserted; hold_o releases normally; state reaches IDLE after GAP.
- flush_i pulse 5 cycles after issue -> hold_o low next cycle; new inst_div_i held off (hold_o=1) until ready+GAP; no writeback of the flushed result; the next divide then completes correctly.
- Divider never asserts ready (busy stuck low after start) -> after 40 cycles timeout_o=1 sticky, hold_o released, no reg_we_o.
- Assert rst=0 during WAIT -> all outputs 0 asynchronously; after release, DIVU 100/10 -> writeback 10.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage issue controller for the iterative RV32M divider.
// It latches the operands of a DIV/DIVU/REM/REMU instruction and holds
// div_start_o until the divider completes. The pipeline is stalled while the
// divide runs. The result is written back with a one-cycle reg_we_o pulse.
// A flush or the watchdog drops the operation, and the divider is then drained
// before the next issue.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   inst_div_i          EX holds a valid divide/remainder instruction
//   op_i                funct3 (100 div, 101 divu, 110 rem, 111 remu)
//   rs1_data_i          dividend
//   rs2_data_i          divisor
//   rd_i                destination register
//   flush_i             pipeline flush
//   hold_o              stall request (combinational)
//   div_start_o         start to divider
//   div_dividend_o      latched dividend
//   div_divisor_o       latched divisor
//   div_op_o            latched funct3
//   div_reg_waddr_o     latched rd tag
//   div_result_i        divider result
//   div_ready_i         divider completion pulse
//   div_busy_i          divider busy
//   div_reg_waddr_i     tag returned with the result
//   reg_we_o            register-file write enable pulse
//   reg_waddr_o         register-file write address
//   reg_wdata_o         register-file write data
//   timeout_o           sticky error flag (watchdog expiry or tag mismatch)
module div_issue_ctrl #(
  parameter int unsigned WATCHDOG = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_div_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        hold_o,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic [4:0]  div_reg_waddr_o,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i,
  input  logic [4:0]  div_reg_waddr_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        timeout_o
);

  localparam int unsigned WD_W = $clog2(WATCHDOG + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]      r_state;
  logic            r_start;
  logic [31:0]     r_dividend;
  logic [31:0]     r_divisor;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [WD_W-1:0] r_wdog;
  logic            r_reg_we;
  logic [4:0]      r_reg_waddr;
  logic [31:0]     r_reg_wdata;
  logic            r_timeout;

  logic [1:0]      w_state_nxt;
  logic            w_start_nxt;
  logic [31:0]     w_dividend_nxt;
  logic [31:0]     w_divisor_nxt;
  logic [2:0]      w_op_nxt;
  logic [4:0]      w_rd_nxt;
  logic [WD_W-1:0] w_wdog_nxt;
  logic            w_reg_we_nxt;
  logic [4:0]      w_reg_waddr_nxt;
  logic [31:0]     w_reg_wdata_nxt;
  logic            w_timeout_nxt;
  logic            w_hold;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_wdog      <= '0;
      r_reg_we    <= 1'b0;
      r_reg_waddr <= '0;
      r_reg_wdata <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start     <= w_start_nxt;
      r_dividend  <= w_dividend_nxt;
      r_divisor   <= w_divisor_nxt;
      r_op        <= w_op_nxt;
      r_rd        <= w_rd_nxt;
      r_wdog      <= w_wdog_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_reg_waddr <= w_reg_waddr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next-state, next-output and stall decode
  always_comb begin
    w_state_nxt     = r_state;
    w_start_nxt     = r_start;
    w_dividend_nxt  = r_dividend;
    w_divisor_nxt   = r_divisor;
    w_op_nxt        = r_op;
    w_rd_nxt        = r_rd;
    w_wdog_nxt      = r_wdog;
    w_reg_we_nxt    = 1'b0;
    w_reg_waddr_nxt = r_reg_waddr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_timeout_nxt   = r_timeout;
    w_hold          = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Stall while a divide waits to issue, including while the divider is busy
        w_hold = inst_div_i & ~flush_i;
        if (inst_div_i && !flush_i && !div_busy_i) begin
          w_dividend_nxt = rs1_data_i;
          w_divisor_nxt  = rs2_data_i;
          w_op_nxt       = op_i;
          w_rd_nxt       = rd_i;
          w_start_nxt    = 1'b1;
          w_wdog_nxt     = '0;
          w_state_nxt    = S_WAIT;
        end
      end

      S_WAIT: begin
        w_hold     = 1'b1;
        w_wdog_nxt = r_wdog + WD_W'(1);
        if (div_ready_i) begin
          // A completion that coincides with a flush is discarded
          w_start_nxt = 1'b0;
          w_state_nxt = S_GAP;
          if (!flush_i) begin
            w_reg_waddr_nxt = div_reg_waddr_i;
            w_reg_wdata_nxt = div_result_i;
            if (div_reg_waddr_i == r_rd) begin
              w_reg_we_nxt = (r_rd != 5'd0);
            end else begin
              w_timeout_nxt = 1'b1;
            end
          end
        end else if (flush_i) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_DRAIN;
        end else if (r_wdog == WD_W'(WATCHDOG - 1)) begin
          w_timeout_nxt = 1'b1;
          w_start_nxt   = 1'b0;
          w_state_nxt   = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Divider may still be running the dropped operation
        w_hold = inst_div_i;
        if (div_ready_i || !div_busy_i) begin
          w_state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        // Guarantees one cycle of start low between operations
        w_hold      = inst_div_i;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_start_nxt = 1'b0;
      end
    endcase
  end

  assign hold_o          = w_hold;
  assign div_start_o     = r_start;
  assign div_dividend_o  = r_dividend;
  assign div_divisor_o   = r_divisor;
  assign div_op_o        = r_op;
  assign div_reg_waddr_o = r_rd;
  assign reg_we_o        = r_reg_we;
  assign reg_waddr_o     = r_reg_waddr;
  assign reg_wdata_o     = r_reg_wdata;
  assign timeout_o       = r_timeout;

endmodule
